// File: rtl/stage_4_mem_wb_pkg.sv
// ============================================================================
// Module   : stage_4_mem_wb_pkg
// Purpose  : Shared memory-op codes, FSM states and byte-enable patterns
//            for the MEM/WB stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package stage_4_mem_wb_pkg;

  localparam logic [2:0] C_OP_READ_8_S  = 3'd0;
  localparam logic [2:0] C_OP_READ_16_S = 3'd1;
  localparam logic [2:0] C_OP_READ_32   = 3'd2;
  localparam logic [2:0] C_OP_READ_8_U  = 3'd3;
  localparam logic [2:0] C_OP_READ_16_U = 3'd4;
  localparam logic [2:0] C_OP_WRITE_8   = 3'd5;
  localparam logic [2:0] C_OP_WRITE_16  = 3'd6;
  localparam logic [2:0] C_OP_WRITE_32  = 3'd7;

  localparam logic [1:0] C_SIZE_BYTE = 2'd0;
  localparam logic [1:0] C_SIZE_HALF = 2'd1;
  localparam logic [1:0] C_SIZE_WORD = 2'd2;

  localparam logic [3:0] C_BE_BYTE = 4'b0001;
  localparam logic [3:0] C_BE_HALF = 4'b0011;
  localparam logic [3:0] C_BE_WORD = 4'b1111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MEM  = 1'b1
  } state_e;

  function automatic logic [1:0] op_size(input logic [2:0] op);
    case (op)
      C_OP_READ_8_S, C_OP_READ_8_U, C_OP_WRITE_8:    op_size = C_SIZE_BYTE;
      C_OP_READ_16_S, C_OP_READ_16_U, C_OP_WRITE_16: op_size = C_SIZE_HALF;
      default:                                       op_size = C_SIZE_WORD;
    endcase
  endfunction

  function automatic logic op_is_write(input logic [2:0] op);
    op_is_write = (op == C_OP_WRITE_8) || (op == C_OP_WRITE_16) ||
                  (op == C_OP_WRITE_32);
  endfunction

endpackage

`default_nettype wire

// File: rtl/stage_4_mem_wb_load_align.sv
// ============================================================================
// Module   : stage_4_mem_wb_load_align
// Purpose  : Selects the addressed byte/halfword lane of a read word
//            (little-endian) and sign- or zero-extends it to 32 bits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stage_4_mem_wb_load_align
  import stage_4_mem_wb_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [31:0] w_shifted;

  assign w_shifted = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    data_o = w_shifted;
    case (op_i)
      C_OP_READ_8_S:  data_o = {{24{w_shifted[7]}}, w_shifted[7:0]};
      C_OP_READ_8_U:  data_o = {24'd0, w_shifted[7:0]};
      C_OP_READ_16_S: data_o = {{16{w_shifted[15]}}, w_shifted[15:0]};
      C_OP_READ_16_U: data_o = {16'd0, w_shifted[15:0]};
      default:        data_o = w_shifted;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/stage_4_mem_wb.sv
// ============================================================================
// Module   : stage_4_mem_wb
// Purpose  : RISC-V MEM/WB stage: data-memory handshake, load alignment and
//            register-file write port. Define MEM_TIMEOUT_EN for the
//            memory-wait timeout and the mem_err output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stage_4_mem_wb
  import stage_4_mem_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_op_type,
  input  logic [2:0]  i_op_mem,
  input  logic [31:0] i_alu_res,
  input  logic [31:0] i_rs_2,
  input  logic [4:0]  i_rd_num,
  input  logic        i_wb_en,
  output logic        stall,
  output logic [4:0]  ex_mem_rd_num,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        reg_op,
  output logic [31:0] w_rd,
  output logic [4:0]  w_rd_num,
`ifdef MEM_TIMEOUT_EN
  output logic        mem_err,
`endif
  output logic        misalign
);

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [4:0]  rd_q, rd_d;
  logic [4:0]  hold_rd_q, hold_rd_d;
  logic        reg_op_q, reg_op_d;
  logic [31:0] w_rd_q, w_rd_d;
  logic [4:0]  w_rd_num_q, w_rd_num_d;
  logic        misalign_q, misalign_d;

  logic [1:0]  w_size;
  logic        w_misaligned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned C_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(TIMEOUT_CYCLES - 1);
  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic               mem_err_q, mem_err_d;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // Request attributes are derived from the incoming instruction in IDLE.
  assign w_size       = op_size(i_op_mem);
  assign w_misaligned = ((w_size == C_SIZE_HALF) && i_alu_res[0]) ||
                        ((w_size == C_SIZE_WORD) && (i_alu_res[1:0] != 2'b00));

  always_comb begin
    w_be    = C_BE_WORD;
    w_wdata = i_rs_2;
    case (w_size)
      C_SIZE_BYTE: begin
        w_be    = C_BE_BYTE << i_alu_res[1:0];
        w_wdata = {4{i_rs_2[7:0]}};
      end
      C_SIZE_HALF: begin
        w_be    = C_BE_HALF << i_alu_res[1:0];
        w_wdata = {2{i_rs_2[15:0]}};
      end
      default: begin
        w_be    = C_BE_WORD;
        w_wdata = i_rs_2;
      end
    endcase
  end

  stage_4_mem_wb_load_align u_load_align (
    .op_i      (op_q),
    .addr_lo_i (addr_lo_q),
    .rdata_i   (i_mem_rdata),
    .data_o    (w_load_data)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    op_d        = op_q;
    addr_lo_d   = addr_lo_q;
    rd_d        = rd_q;
    hold_rd_d   = 5'd0;
    reg_op_d    = 1'b0;
    w_rd_d      = w_rd_q;
    w_rd_num_d  = w_rd_num_q;
    misalign_d  = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d       = cnt_q;
    mem_err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          if (!i_op_type) begin
            reg_op_d   = i_wb_en && (i_rd_num != 5'd0);
            w_rd_d     = i_alu_res;
            w_rd_num_d = i_rd_num;
            hold_rd_d  = i_rd_num;
          end else if (w_misaligned) begin
            misalign_d = 1'b1;
          end else begin
            state_d     = ST_MEM;
            mem_req_d   = 1'b1;
            mem_we_d    = op_is_write(i_op_mem);
            mem_addr_d  = {i_alu_res[31:2], 2'b00};
            mem_wdata_d = w_wdata;
            mem_be_d    = w_be;
            op_d        = i_op_mem;
            addr_lo_d   = i_alu_res[1:0];
            rd_d        = i_rd_num;
`ifdef MEM_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end
        end
      end
      ST_MEM: begin
        if (i_mem_ack) begin
          state_d     = ST_IDLE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = 32'd0;
          mem_wdata_d = 32'd0;
          mem_be_d    = 4'd0;
          hold_rd_d   = rd_q;
          if (!mem_we_q) begin
            reg_op_d   = (rd_q != 5'd0);
            w_rd_d     = w_load_data;
            w_rd_num_d = rd_q;
          end
`ifdef MEM_TIMEOUT_EN
        end else if (cnt_q == C_CNT_LAST) begin
          // Abandon the access: no writeback, flag the error instead.
          state_d     = ST_IDLE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = 32'd0;
          mem_wdata_d = 32'd0;
          mem_be_d    = 4'd0;
          mem_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_be_q    <= 4'd0;
      op_q        <= 3'd0;
      addr_lo_q   <= 2'd0;
      rd_q        <= 5'd0;
      hold_rd_q   <= 5'd0;
      reg_op_q    <= 1'b0;
      w_rd_q      <= 32'd0;
      w_rd_num_q  <= 5'd0;
      misalign_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= '0;
      mem_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      op_q        <= op_d;
      addr_lo_q   <= addr_lo_d;
      rd_q        <= rd_d;
      hold_rd_q   <= hold_rd_d;
      reg_op_q    <= reg_op_d;
      w_rd_q      <= w_rd_d;
      w_rd_num_q  <= w_rd_num_d;
      misalign_q  <= misalign_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
      mem_err_q   <= mem_err_d;
`endif
    end
  end

  assign stall         = (state_q == ST_MEM) && !i_mem_ack;
  assign ex_mem_rd_num = (state_q == ST_MEM) ? rd_q : hold_rd_q;
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_be        = mem_be_q;
  assign reg_op        = reg_op_q;
  assign w_rd          = w_rd_q;
  assign w_rd_num      = w_rd_num_q;
  assign misalign      = misalign_q;
`ifdef MEM_TIMEOUT_EN
  assign mem_err       = mem_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stage_4_mem_wb.sv
// ============================================================================
// Module   : tb_stage_4_mem_wb
// Purpose  : Directed self-checking bench for the MEM/WB stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stage_4_mem_wb;
  import stage_4_mem_wb_pkg::*;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        i_op_type;
  logic [2:0]  i_op_mem;
  logic [31:0] i_alu_res;
  logic [31:0] i_rs_2;
  logic [4:0]  i_rd_num;
  logic        i_wb_en;
  logic        stall;
  logic [4:0]  ex_mem_rd_num;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        reg_op;
  logic [31:0] w_rd;
  logic [4:0]  w_rd_num;
  logic        misalign;
`ifdef MEM_TIMEOUT_EN
  logic        mem_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stage_4_mem_wb #(.TIMEOUT_CYCLES(255)) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_valid       (i_valid),
    .i_op_type     (i_op_type),
    .i_op_mem      (i_op_mem),
    .i_alu_res     (i_alu_res),
    .i_rs_2        (i_rs_2),
    .i_rd_num      (i_rd_num),
    .i_wb_en       (i_wb_en),
    .stall         (stall),
    .ex_mem_rd_num (ex_mem_rd_num),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .i_mem_ack     (i_mem_ack),
    .i_mem_rdata   (i_mem_rdata),
    .reg_op        (reg_op),
    .w_rd          (w_rd),
    .w_rd_num      (w_rd_num),
`ifdef MEM_TIMEOUT_EN
    .mem_err       (mem_err),
`endif
    .misalign      (misalign)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic op_type, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] rs2, input logic [4:0] rd, input logic wb);
    i_valid   = 1'b1;
    i_op_type = op_type;
    i_op_mem  = op;
    i_alu_res = addr;
    i_rs_2    = rs2;
    i_rd_num  = rd;
    i_wb_en   = wb;
  endtask

  // Issue a memory op, hold it outstanding for 'waits' cycles, then ack it.
  task automatic mem_access(input string tag, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] rs2, input logic [4:0] rd, input int waits,
                            input logic [31:0] rdata, input logic exp_we,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata);
    drive(1'b1, op, addr, rs2, rd, 1'b1);
    tick();
    i_valid = 1'b0;
    check_eq({tag, ".req"},  {31'd0, mem_req}, 32'd1);
    check_eq({tag, ".we"},   {31'd0, mem_we}, {31'd0, exp_we});
    check_eq({tag, ".addr"}, mem_addr, exp_addr);
    check_eq({tag, ".be"},   {28'd0, mem_be}, {28'd0, exp_be});
    check_eq({tag, ".exrd"}, {27'd0, ex_mem_rd_num}, {27'd0, rd});
    if (exp_we) check_eq({tag, ".wdata"}, mem_wdata, exp_wdata);
    for (int i = 0; i < waits; i++) begin
      // A younger ALU op offered during the stall must be ignored.
      drive(1'b0, C_OP_READ_32, 32'h0000_0BAD, 32'd0, 5'd6, 1'b1);
      check_eq({tag, ".stall"}, {31'd0, stall}, 32'd1);
      check_eq({tag, ".stable_addr"}, mem_addr, exp_addr);
      tick();
      check_eq({tag, ".no_wb_in_stall"}, {31'd0, reg_op}, 32'd0);
    end
    i_valid     = 1'b0;
    i_mem_ack   = 1'b1;
    i_mem_rdata = rdata;
    #1;
    check_eq({tag, ".stall_on_ack"}, {31'd0, stall}, 32'd0);
    tick();
    i_mem_ack = 1'b0;
    check_eq({tag, ".req_drop"}, {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    i_rst = 1'b0; i_valid = 1'b0; i_op_type = 1'b0; i_op_mem = 3'd0;
    i_alu_res = 32'd0; i_rs_2 = 32'd0; i_rd_num = 5'd0; i_wb_en = 1'b0;
    i_mem_ack = 1'b0; i_mem_rdata = 32'd0;
    tick(); tick();
    check_eq("rst.reg_op", {31'd0, reg_op}, 32'd0);
    check_eq("rst.mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst.stall", {31'd0, stall}, 32'd0);
    check_eq("rst.w_rd", w_rd, 32'd0);
    check_eq("rst.exrd", {27'd0, ex_mem_rd_num}, 32'd0);
    i_rst = 1'b1;
    tick();

    // ALU writeback
    drive(1'b0, C_OP_READ_32, 32'h0000_1234, 32'd0, 5'd5, 1'b1);
    #1;
    check_eq("alu.stall", {31'd0, stall}, 32'd0);
    tick();
    i_valid = 1'b0;
    check_eq("alu.reg_op", {31'd0, reg_op}, 32'd1);
    check_eq("alu.w_rd", w_rd, 32'h0000_1234);
    check_eq("alu.w_rd_num", {27'd0, w_rd_num}, 32'd5);
    check_eq("alu.exrd", {27'd0, ex_mem_rd_num}, 32'd5);
    tick();
    check_eq("alu.pulse", {31'd0, reg_op}, 32'd0);
    check_eq("alu.exrd_clr", {27'd0, ex_mem_rd_num}, 32'd0);

    // LB / LBU at 0x103
    mem_access("lb", C_OP_READ_8_S, 32'h0000_0103, 32'd0, 5'd10, 3, 32'h80AA_BBCC,
               1'b0, 32'h0000_0100, 4'b1000, 32'd0);
    check_eq("lb.reg_op", {31'd0, reg_op}, 32'd1);
    check_eq("lb.w_rd", w_rd, 32'hFFFF_FF80);
    check_eq("lb.w_rd_num", {27'd0, w_rd_num}, 32'd10);
    check_eq("lb.exrd", {27'd0, ex_mem_rd_num}, 32'd10);
    tick();
    check_eq("lb.pulse", {31'd0, reg_op}, 32'd0);
    mem_access("lbu", C_OP_READ_8_U, 32'h0000_0103, 32'd0, 5'd11, 3, 32'h80AA_BBCC,
               1'b0, 32'h0000_0100, 4'b1000, 32'd0);
    check_eq("lbu.w_rd", w_rd, 32'h0000_0080);
    check_eq("lbu.reg_op", {31'd0, reg_op}, 32'd1);

    // SH at 0x202 acked immediately
    mem_access("sh", C_OP_WRITE_16, 32'h0000_0202, 32'hDEAD_BEEF, 5'd0, 0, 32'd0,
               1'b1, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF);
    check_eq("sh.reg_op", {31'd0, reg_op}, 32'd0);

    // SB at 0x401
    mem_access("sb", C_OP_WRITE_8, 32'h0000_0401, 32'h1122_3344, 5'd0, 1, 32'd0,
               1'b1, 32'h0000_0400, 4'b0010, 32'h4444_4444);
    check_eq("sb.reg_op", {31'd0, reg_op}, 32'd0);

    // LH signed, upper half
    mem_access("lh", C_OP_READ_16_S, 32'h0000_0302, 32'd0, 5'd7, 1, 32'h8001_5555,
               1'b0, 32'h0000_0300, 4'b1100, 32'd0);
    check_eq("lh.w_rd", w_rd, 32'hFFFF_8001);

    // LHU lower half
    mem_access("lhu", C_OP_READ_16_U, 32'h0000_0000, 32'd0, 5'd8, 0, 32'h1234_F00D,
               1'b0, 32'h0000_0000, 4'b0011, 32'd0);
    check_eq("lhu.w_rd", w_rd, 32'h0000_F00D);

    // LW aligned
    mem_access("lw", C_OP_READ_32, 32'h0000_0304, 32'd0, 5'd3, 2, 32'hCAFE_F00D,
               1'b0, 32'h0000_0304, 4'b1111, 32'd0);
    check_eq("lw.w_rd", w_rd, 32'hCAFE_F00D);
    check_eq("lw.w_rd_num", {27'd0, w_rd_num}, 32'd3);

    // Load to x0: access happens, no writeback
    mem_access("ld_x0", C_OP_READ_32, 32'h0000_0300, 32'd0, 5'd0, 1, 32'h1234_5678,
               1'b0, 32'h0000_0300, 4'b1111, 32'd0);
    check_eq("ld_x0.reg_op", {31'd0, reg_op}, 32'd0);

    // Misaligned LW and LH
    drive(1'b1, C_OP_READ_32, 32'h0000_0101, 32'd0, 5'd4, 1'b1);
    tick();
    i_valid = 1'b0;
    check_eq("mis_lw.pulse", {31'd0, misalign}, 32'd1);
    check_eq("mis_lw.req", {31'd0, mem_req}, 32'd0);
    check_eq("mis_lw.reg_op", {31'd0, reg_op}, 32'd0);
    check_eq("mis_lw.stall", {31'd0, stall}, 32'd0);
    tick();
    check_eq("mis_lw.pulse_end", {31'd0, misalign}, 32'd0);
    check_eq("mis_lw.req_later", {31'd0, mem_req}, 32'd0);
    drive(1'b1, C_OP_READ_16_U, 32'h0000_0105, 32'd0, 5'd4, 1'b1);
    tick();
    i_valid = 1'b0;
    check_eq("mis_lh.pulse", {31'd0, misalign}, 32'd1);
    check_eq("mis_lh.req", {31'd0, mem_req}, 32'd0);

    // Reset during MEM abandons the access
    drive(1'b1, C_OP_READ_32, 32'h0000_0500, 32'd0, 5'd9, 1'b1);
    tick();
    i_valid = 1'b0;
    check_eq("rstmem.req", {31'd0, mem_req}, 32'd1);
    i_rst = 1'b0;
    tick();
    check_eq("rstmem.req_clr", {31'd0, mem_req}, 32'd0);
    check_eq("rstmem.stall", {31'd0, stall}, 32'd0);
    check_eq("rstmem.exrd", {27'd0, ex_mem_rd_num}, 32'd0);
    i_rst = 1'b1;
    i_mem_ack = 1'b1;
    i_mem_rdata = 32'h5A5A_5A5A;
    tick();
    i_mem_ack = 1'b0;
    check_eq("rstmem.late_ack_wb", {31'd0, reg_op}, 32'd0);
    check_eq("rstmem.late_ack_req", {31'd0, mem_req}, 32'd0);

`ifdef MEM_TIMEOUT_EN
    begin
      int cycles = 0;
      bit seen = 1'b0;
      drive(1'b1, C_OP_READ_32, 32'h0000_0600, 32'd0, 5'd12, 1'b1);
      tick();
      i_valid = 1'b0;
      while (!seen && cycles < 300) begin
        tick();
        cycles++;
        if (mem_err) seen = 1'b1;
      end
      check_eq("tmo.seen", {31'd0, seen}, 32'd1);
      check_eq("tmo.cycles", cycles, 32'd255);
      check_eq("tmo.req", {31'd0, mem_req}, 32'd0);
      check_eq("tmo.reg_op", {31'd0, reg_op}, 32'd0);
      tick();
      check_eq("tmo.pulse", {31'd0, mem_err}, 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
